if_id_fetch_stage: RTL and testbench

Instruction-fetch stage and IF/ID pipeline register of the 5-stage RISC-V core: owns the PC, drives the synchronous instruction memory, and presents the fetched instruction to decode. It is the consumer of the hazard detection unit's `pc_write` / `if_id_write` stall controls and of the EX-stage branch redirect. It honours stalls, squashes wrong-path instructions on a taken branch, and inserts bubbles into decode.

---
 rtl/if_id_fetch_stage_if.sv | 28 ++
 rtl/if_id_fetch_stage.sv | 117 +++++++++++
 tb/tb_if_id_fetch_stage.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/if_id_fetch_stage_if.sv
// Fetch-stage bus: hazard controls, EX redirect, instruction-memory port and decode-side outputs.
// master = fetch stage, slave = surrounding core / memory.
interface if_id_fetch_stage_if #(
   parameter int unsigned XLEN = 32
);
   logic            pc_write;
   logic            if_id_write;
   logic            ex_br_taken;
   logic [XLEN-1:0] ex_br_target;
   logic [XLEN-1:0] imem_addr;
   logic [31:0]     imem_rdata;
   logic [XLEN-1:0] if_pc;
   logic [XLEN-1:0] id_pc;
   logic [31:0]     id_instr;
   logic            id_valid;
   logic [31:0]     perf_stall_cnt;
   logic [31:0]     perf_flush_cnt;

   modport master (
      input  pc_write, if_id_write, ex_br_taken, ex_br_target, imem_rdata,
      output imem_addr, if_pc, id_pc, id_instr, id_valid, perf_stall_cnt, perf_flush_cnt
   );

   modport slave (
      output pc_write, if_id_write, ex_br_taken, ex_br_target, imem_rdata,
      input  imem_addr, if_pc, id_pc, id_instr, id_valid, perf_stall_cnt, perf_flush_cnt
   );
endinterface

// File: rtl/if_id_fetch_stage.sv
// Instruction fetch stage: owns the PC, drives the synchronous imem and holds the IF/ID register.
// Define IF_PERF_CNT_EN to build the stall/flush performance counters (tied to 0 otherwise).
module if_id_fetch_stage #(
   parameter int unsigned     XLEN     = 32,
   parameter logic [XLEN-1:0] RESET_PC = '0
) (
   input logic                 clk,
   input logic                 rst_n,
   if_id_fetch_stage_if.master bus
);
   localparam int unsigned     IW        = 32;
   localparam logic [0:0]      ST_BOOT   = 1'b0;
   localparam logic [0:0]      ST_RUN    = 1'b1;
   localparam logic [IW-1:0]   NOP_INSTR = 32'h0000_0013;
   localparam logic [XLEN-1:0] PC_STEP   = XLEN'(4);

   logic [0:0]      state_q, state_d;
   logic [XLEN-1:0] pc_q, pc_d, pc_next_c;
   logic [XLEN-1:0] id_pc_q, id_pc_d;
   logic [IW-1:0]   id_instr_q, id_instr_d;
   logic            id_valid_q, id_valid_d;
   logic            unused_tgt_lsb;

   // Redirect targets are word aligned; the low two bits carry no information.
   assign unused_tgt_lsb = ^bus.ex_br_target[1:0];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_BOOT;
         pc_q       <= RESET_PC;
         id_pc_q    <= '0;
         id_instr_q <= NOP_INSTR;
         id_valid_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         id_pc_q    <= id_pc_d;
         id_instr_q <= id_instr_d;
         id_valid_q <= id_valid_d;
      end
   end

   always_comb begin
      state_d    = ST_RUN;
      pc_next_c  = pc_q;
      pc_d       = pc_q;
      id_pc_d    = id_pc_q;
      id_instr_d = id_instr_q;
      id_valid_d = id_valid_q;
      case (state_q)
         ST_BOOT: begin
            pc_next_c  = RESET_PC;
            id_instr_d = NOP_INSTR;
            id_valid_d = 1'b0;
         end
         default: begin
            if (bus.ex_br_taken) begin
               pc_next_c = {bus.ex_br_target[XLEN-1:2], 2'b00};
            end else if (!bus.pc_write) begin
               pc_next_c = pc_q;
            end else begin
               pc_next_c = pc_q + PC_STEP;
            end
            pc_d = pc_next_c;
            // Redirect squashes decode even under a hold; a held PC must not feed decode twice.
            if (bus.ex_br_taken || (bus.if_id_write && !bus.pc_write)) begin
               id_instr_d = NOP_INSTR;
               id_valid_d = 1'b0;
            end else if (bus.if_id_write) begin
               id_pc_d    = pc_q;
               id_instr_d = bus.imem_rdata;
               id_valid_d = 1'b1;
            end
         end
      endcase
   end

   assign bus.imem_addr = pc_next_c;
   assign bus.if_pc     = pc_q;
   assign bus.id_pc     = id_pc_q;
   assign bus.id_instr  = id_instr_q;
   assign bus.id_valid  = id_valid_q;

`ifdef IF_PERF_CNT_EN
   logic [31:0] stall_cnt_q, stall_cnt_d;
   logic [31:0] flush_cnt_q, flush_cnt_d;

   // Saturating event counters, active only in RUN.
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      if (state_q == ST_RUN) begin
         if (bus.ex_br_taken) begin
            if (flush_cnt_q != 32'hFFFF_FFFF) flush_cnt_d = flush_cnt_q + 32'd1;
         end else if (!bus.pc_write) begin
            if (stall_cnt_q != 32'hFFFF_FFFF) stall_cnt_d = stall_cnt_q + 32'd1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign bus.perf_stall_cnt = stall_cnt_q;
   assign bus.perf_flush_cnt = flush_cnt_q;
`else
   assign bus.perf_stall_cnt = '0;
   assign bus.perf_flush_cnt = '0;
`endif
endmodule

// File: tb/tb_if_id_fetch_stage.sv
// Self-checking bench for if_id_fetch_stage: directed bring-up/stall/branch cases, an async reset
// pulse, a wrap-around instance and a randomized run checked against a cycle-level reference model.
module tb_if_id_fetch_stage;
   localparam logic [31:0] NOP     = 32'h0000_0013;
   localparam logic [31:0] WRAP_PC = 32'hFFFF_FFF8;

   logic clk = 1'b0;
   logic rst_n;
   logic [31:0] salt = 32'h0;
   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   if_id_fetch_stage_if #(.XLEN(32)) bus ();
   if_id_fetch_stage_if #(.XLEN(32)) bus_w ();

   if_id_fetch_stage #(.XLEN(32), .RESET_PC(32'h0)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
   if_id_fetch_stage #(.XLEN(32), .RESET_PC(WRAP_PC)) dut_w (.clk(clk), .rst_n(rst_n), .bus(bus_w));

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return a ^ salt;
   endfunction

   // Synchronous instruction memories: data for the address seen at the edge.
   always @(posedge clk) begin
      bus.imem_rdata   <= mem_word(bus.imem_addr);
      bus_w.imem_rdata <= bus_w.imem_addr;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
      end
   endtask

   // Reference model: architectural view of fetch pointer, decode slot and event counts.
   bit          m_boot;
   logic [31:0] m_pc, m_id_pc, m_id_instr, m_rdata, m_stall, m_flush;
   logic        m_id_valid;
   int          cyc;
   logic        in_pw, in_iw, in_bt;
   logic [31:0] in_tgt;

   task automatic model_reset();
      m_boot = 1'b1; m_pc = 32'h0; m_id_pc = 32'h0; m_id_instr = NOP; m_id_valid = 1'b0;
      m_stall = 32'h0; m_flush = 32'h0; m_rdata = 32'h0; cyc = 0;
   endtask

   function automatic logic [31:0] exp_addr();
      if (m_boot) return 32'h0;
      if (in_bt) return in_tgt & 32'hFFFF_FFFC;
      if (!in_pw) return m_pc;
      return m_pc + 32'd4;
   endfunction

   task automatic model_advance();
      logic [31:0] a;
      a = exp_addr();
      if (m_boot || in_bt || (in_iw && !in_pw)) begin
         m_id_instr = NOP; m_id_valid = 1'b0;
      end else if (in_iw) begin
         m_id_pc = m_pc; m_id_instr = m_rdata; m_id_valid = 1'b1;
      end
      if (!m_boot) begin
         if (in_bt) begin
            if (m_flush != 32'hFFFF_FFFF) m_flush = m_flush + 32'd1;
         end else if (!in_pw) begin
            if (m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 32'd1;
         end
         m_pc = a;
      end
      m_rdata = mem_word(a);
      m_boot = 1'b0;
      cyc++;
   endtask

   task automatic compare(input bit stream_chk);
      chk("imem_addr", bus.imem_addr, exp_addr());
      chk("if_pc", bus.if_pc, m_pc);
      chk("id_pc", bus.id_pc, m_id_pc);
      chk("id_instr", bus.id_instr, m_id_instr);
      chk("id_valid", 32'(bus.id_valid), 32'(m_id_valid));
`ifdef IF_PERF_CNT_EN
      chk("stall_cnt", bus.perf_stall_cnt, m_stall);
      chk("flush_cnt", bus.perf_flush_cnt, m_flush);
`else
      chk("stall_cnt", bus.perf_stall_cnt, 32'h0);
      chk("flush_cnt", bus.perf_flush_cnt, 32'h0);
`endif
      if (cyc < 4) chk("wrap_addr", bus_w.imem_addr, WRAP_PC + 32'(cyc) * 32'd4);
      if (stream_chk && bus.id_valid) chk("stream", bus.id_instr, mem_word(bus.id_pc));
   endtask

   // Called just after a rising edge; checks mid-cycle and returns just after the next edge.
   task automatic step(input logic pw, input logic iw, input logic bt, input logic [31:0] tgt,
                       input bit stream_chk = 1'b0);
      in_pw = pw; in_iw = iw; in_bt = bt; in_tgt = tgt;
      bus.pc_write = pw; bus.if_id_write = iw; bus.ex_br_taken = bt; bus.ex_br_target = tgt;
      #4;
      compare(stream_chk);
      model_advance();
      @(posedge clk);
      #1;
   endtask

   task automatic check_reset(input string tag);
      chk({tag, "_imem_addr"}, bus.imem_addr, 32'h0);
      chk({tag, "_if_pc"}, bus.if_pc, 32'h0);
      chk({tag, "_id_pc"}, bus.id_pc, 32'h0);
      chk({tag, "_id_instr"}, bus.id_instr, NOP);
      chk({tag, "_id_valid"}, 32'(bus.id_valid), 32'h0);
      chk({tag, "_stall_cnt"}, bus.perf_stall_cnt, 32'h0);
      chk({tag, "_flush_cnt"}, bus.perf_flush_cnt, 32'h0);
      chk({tag, "_wrap_addr"}, bus_w.imem_addr, WRAP_PC);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog timeout t=%0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      int k;
      rst_n = 1'b0;
      bus.pc_write = 1'b1; bus.if_id_write = 1'b1; bus.ex_br_taken = 1'b0; bus.ex_br_target = '0;
      bus_w.pc_write = 1'b1; bus_w.if_id_write = 1'b1; bus_w.ex_br_taken = 1'b0;
      bus_w.ex_br_target = '0;
      repeat (3) @(posedge clk);
      #1;
      check_reset("rst");
      rst_n = 1'b1;
      model_reset();

      // Bring-up with word(addr)=addr, then load-use stall while id_pc=8.
      k = 0;
      while (!(bus.id_valid && bus.id_pc == 32'd8) && k < 20) begin
         step(1'b1, 1'b1, 1'b0, 32'h0);
         k++;
      end
      chk("reach_id8", bus.id_pc, 32'd8);
      step(1'b0, 1'b0, 1'b0, 32'h0);
      step(1'b0, 1'b0, 1'b0, 32'h0);

      // Taken branch to 0x103 while if_pc=20.
      k = 0;
      while (bus.if_pc != 32'd20 && k < 20) begin
         step(1'b1, 1'b1, 1'b0, 32'h0);
         k++;
      end
      chk("reach_if20", bus.if_pc, 32'd20);
      step(1'b1, 1'b1, 1'b1, 32'h0000_0103);
      repeat (4) step(1'b1, 1'b1, 1'b0, 32'h0);

      // Redirect that coincides with a full stall, plus the two partial-hold mixes.
      step(1'b0, 1'b0, 1'b1, 32'h0000_0242);
      repeat (3) step(1'b1, 1'b1, 1'b0, 32'h0);
      step(1'b1, 1'b0, 1'b0, 32'h0);
      step(1'b0, 1'b1, 1'b0, 32'h0);
      repeat (3) step(1'b1, 1'b1, 1'b0, 32'h0);

      // 1-unit asynchronous reset pulse between clock edges.
      rst_n = 1'b0;
      #1;
      check_reset("async");
      rst_n = 1'b1;
      salt = $urandom;
      model_reset();

      for (int i = 0; i < 1500; i++) begin
         logic pw, iw, bt;
         int r;
         r  = int'($urandom_range(0, 99));
         pw = 1'b1; iw = 1'b1; bt = 1'b0;
         if (r < 20) begin
            pw = 1'b0; iw = 1'b0;
         end else if (r < 25) begin
            iw = 1'b0;
         end else if (r < 30) begin
            pw = 1'b0;
         end
         if ($urandom_range(0, 7) == 0) bt = 1'b1;
         step(pw, iw, bt, $urandom, 1'b1);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
